// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with run-time pattern/length, overlap mode,
// registered one-cycle match pulse and saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               seq_in,
    input  logic               in_valid,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               seq_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               seq_out_q, seq_out_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] nh;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   nf;
    logic               hit;

    always_comb begin
        nh = {hist_q[MAX_LEN-2:0], seq_in};
        nf = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + LEN_W'(1);
        // Only the newest len_q bits of the history take part in the compare.
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        hit = !cfg_err_q && (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);

        hist_d    = hist_q;
        pat_d     = pat_q;
        fill_d    = fill_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_err_q;
        cnt_d     = cnt_q;
        seq_out_d = 1'b0;

        if (load) begin
            pat_d     = pattern;
            len_d     = pat_len;
            ovl_d     = overlap;
            cfg_err_d = (pat_len == '0) || (pat_len > LEN_W'(MAX_LEN));
            hist_d    = '0;
            fill_d    = '0;
            cnt_d     = '0;
        end else if (in_valid) begin
            hist_d    = nh;
            seq_out_d = hit;
            fill_d    = (hit && !ovl_q) ? '0 : nf;
            if (hit && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q    <= '0;
            pat_q     <= '0;
            fill_q    <= '0;
            len_q     <= LEN_W'(1);
            ovl_q     <= 1'b1;
            seq_out_q <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            fill_q    <= fill_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            seq_out_q <= seq_out_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign seq_out     = seq_out_q;
    assign match_count = cnt_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               seq_in = 1'b0;
    logic               in_valid = 1'b0;
    logic               load = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap = 1'b0;
    logic               seq_out;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
        .load(load), .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .seq_out(seq_out), .match_count(match_count), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    out;
        int    cnt;
        int    err;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the valid bits seen since the last clear, newest at the back.
    bit   m_bits[$];
    int   m_pat, m_len, m_ovl, m_err, m_cnt, m_out;
    string cur_tag = "reset";

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".seq_out"}, int'(seq_out), e.out);
            chk({e.tag, ".match_count"}, int'(match_count), e.cnt);
            chk({e.tag, ".cfg_err"}, int'(cfg_err), e.err);
        end
    end

    function automatic bit pattern_matches();
        int n = m_bits.size();
        if (m_err != 0 || n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_bits[n-1-k] != ((m_pat >> k) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input bit rst, input bit ld, input bit v, input bit b,
                        input int p, input int l, input bit o);
        exp_t e;
        @(negedge clock);
        reset    = rst;
        load     = ld;
        in_valid = v;
        seq_in   = b;
        pattern  = MAX_LEN'(p);
        pat_len  = LEN_W'(l);
        overlap  = o;
        if (rst) begin
            m_bits.delete();
            m_pat = 0; m_len = 1; m_ovl = 1; m_err = 0; m_cnt = 0; m_out = 0;
        end else if (ld) begin
            m_bits.delete();
            m_pat = p; m_len = l; m_ovl = o;
            m_err = (l == 0 || l > MAX_LEN) ? 1 : 0;
            m_cnt = 0; m_out = 0;
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            m_out = pattern_matches() ? 1 : 0;
            if (m_out != 0) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (m_ovl == 0) m_bits.delete();
            end
        end else begin
            m_out = 0;
        end
        e.out = m_out; e.cnt = m_cnt; e.err = m_err; e.tag = cur_tag;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask
    task automatic do_load(input int p, input int l, input bit o);
        step(1'b0, 1'b1, 1'b0, 1'b0, p, l, o);
    endtask
    task automatic send(input bit b);
        step(1'b0, 1'b0, 1'b1, b, 0, 0, 1'b0);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask
    task automatic send_word(input int w, input int n);
        for (int i = n - 1; i >= 0; i--) send(bit'((w >> i) & 1));
    endtask

    initial begin
        cur_tag = "reset";
        do_reset();
        do_reset();

        cur_tag = "t1_overlap";
        do_load(8'h05, 4, 1'b1);
        send_word(6'b010101, 6);
        idle();

        cur_tag = "t2_nonoverlap";
        do_load(8'h05, 4, 1'b0);
        send_word(8'b01010101, 8);
        idle();

        cur_tag = "t3_gaps";
        do_load(8'h05, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(bit'(i & 1));
            repeat (i + 1) idle();
        end

        cur_tag = "t4_maxlen";
        do_load(8'hA5, 8, 1'b1);
        send_word(8'b10100101, 8);
        send_word(8'b10100101, 8);
        cur_tag = "t4_len0";
        do_load(8'hA5, 0, 1'b1);
        send_word(8'b10100101, 8);
        for (int i = 0; i < 8; i++) send(1'b0);
        cur_tag = "t4_len9";
        do_load(8'h01, 9, 1'b1);
        for (int i = 0; i < 6; i++) send(1'b1);

        cur_tag = "t5_saturate";
        do_load(8'h01, 1, 1'b1);
        for (int i = 0; i < 300; i++) send(1'b1);
        send(1'b0);
        send(1'b1);

        cur_tag = "t6_reset_mid";
        do_load(8'h05, 4, 1'b1);
        send_word(3'b010, 3);
        do_reset();
        do_load(8'h05, 4, 1'b1);
        send(1'b1);
        cur_tag = "t6_load_mid";
        send_word(8'b01010101, 8);
        do_load(8'h05, 4, 1'b1);
        send(1'b1);
        send_word(4'b0101, 4);
        cur_tag = "t6_load_with_valid";
        send_word(3'b010, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 4, 1'b1);
        send_word(4'b0101, 4);

        cur_tag = "random";
        for (int n = 0; n < 1500; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                int l = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) * int'($urandom_range(0, 1))
                                                    : $urandom_range(1, MAX_LEN);
                do_load($urandom_range(0, 255), l, bit'($urandom_range(0, 1)));
            end else if (r < 30) begin
                idle();
            end else begin
                send(bit'($urandom_range(0, 1)));
            end
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
